mont_mult_serial: RTL and testbench

- Radix-2 bit-serial Montgomery modular multiplier: result = A·B·R⁻¹ mod N, where R = 2^DATA_LENGTH.
- Sits directly downstream of the R mod N / R² mod N constant generator and consumes its outputs.
- Operand conversion into the Montgomery domain uses B = R² mod N; conversion back uses B = 1.
- It is the core datapath stage of the RSA decryption exponentiation loop.

---
 rtl/mont_mult_serial_if.sv | 23 ++
 rtl/mont_mult_serial.sv | 115 +++++++++++
 tb/tb_mont_mult_serial.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mont_mult_serial_if.sv
// Operand/result bundle for the bit-serial Montgomery multiplier.
interface mont_mult_serial_if #(
   parameter int DATA_LENGTH = 1024
);
   logic                   start;
   logic [DATA_LENGTH-1:0] A;
   logic [DATA_LENGTH-1:0] B;
   logic [DATA_LENGTH-1:0] N;
   logic [DATA_LENGTH-1:0] result;
   logic                   busy;
   logic                   done;
   logic                   err;

   modport master (
      output start, A, B, N,
      input  result, busy, done, err
   );

   modport slave (
      input  start, A, B, N,
      output result, busy, done, err
   );
endinterface

// File: rtl/mont_mult_serial.sv
// Radix-2 bit-serial Montgomery multiplier: result = A*B*2^-DATA_LENGTH mod N.
// Optional MONT_ODD_CHECK_EN rejects even or trivial moduli with err and an early done.
module mont_mult_serial #(
   parameter int DATA_LENGTH = 1024
) (
   input  logic               clk,
   input  logic               rst,
   mont_mult_serial_if.slave  bus
);
   localparam int SW = DATA_LENGTH + 2;
   localparam int CW = $clog2(DATA_LENGTH + 1);

   typedef enum logic [1:0] {IDLE, ITER, FINAL} state_t;

   state_t                 state_q;
   logic [DATA_LENGTH-1:0] a_q;
   logic [DATA_LENGTH-1:0] b_q;
   logic [DATA_LENGTH-1:0] n_q;
   logic [DATA_LENGTH-1:0] result_q;
   logic [SW-1:0]          s_q;
   logic [SW-1:0]          add_b_d;
   logic [SW-1:0]          add_n_d;
   logic [SW-1:0]          s_d;
   logic [CW-1:0]          cnt_q;
   logic                   busy_q;
   logic                   done_q;

   // S < 2N on entry keeps S + B + N below 4N, so SW bits never overflow.
   function automatic logic [DATA_LENGTH-1:0] final_reduce(
      input logic [SW-1:0]          s,
      input logic [DATA_LENGTH-1:0] n
   );
      logic [SW-1:0] diff;
      diff = s - {2'b00, n};
      if (s >= {2'b00, n}) final_reduce = diff[DATA_LENGTH-1:0];
      else                 final_reduce = s[DATA_LENGTH-1:0];
   endfunction

   assign add_b_d = s_q + (a_q[0] ? {2'b00, b_q} : {SW{1'b0}});
   assign add_n_d = add_b_d + (add_b_d[0] ? {2'b00, n_q} : {SW{1'b0}});
   assign s_d     = add_n_d >> 1;

`ifdef MONT_ODD_CHECK_EN
   logic err_q;
   logic n_bad;

   assign n_bad   = ~bus.N[0] | (bus.N[DATA_LENGTH-1:1] == '0);
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         s_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef MONT_ODD_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_q   <= bus.A;
                  b_q   <= bus.B;
                  n_q   <= bus.N;
                  s_q   <= '0;
                  cnt_q <= CW'(DATA_LENGTH);
`ifdef MONT_ODD_CHECK_EN
                  if (n_bad) begin
                     // Skip the loop entirely; FINAL only emits the done pulse.
                     err_q    <= 1'b1;
                     result_q <= '0;
                     state_q  <= FINAL;
                  end else begin
                     err_q   <= 1'b0;
                     busy_q  <= 1'b1;
                     state_q <= ITER;
                  end
`else
                  busy_q  <= 1'b1;
                  state_q <= ITER;
`endif
               end
            end
            ITER: begin
               s_q   <= s_d;
               a_q   <= a_q >> 1;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_q <= FINAL;
            end
            FINAL: begin
`ifdef MONT_ODD_CHECK_EN
               if (!err_q) result_q <= final_reduce(s_q, n_q);
`else
               result_q <= final_reduce(s_q, n_q);
`endif
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.result = result_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_mont_mult_serial.sv
// Directed-vector bench for mont_mult_serial with DATA_LENGTH=8 (R=256).
module tb_mont_mult_serial;
   localparam int DL = 8;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   mont_mult_serial_if #(.DATA_LENGTH(DL)) bus ();

   mont_mult_serial #(.DATA_LENGTH(DL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launches one operation from IDLE; lat = edges from acceptance to done, -1 on timeout.
   task automatic run_op(input logic [DL-1:0] a, input logic [DL-1:0] b,
                         input logic [DL-1:0] n, output int lat,
                         output logic [DL-1:0] res, output logic err_seen);
      bus.A = a; bus.B = b; bus.N = n; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus.done === 1'b1) begin
            lat = k;
            break;
         end
      end
      res      = bus.result;
      err_seen = bus.err;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (bus.result !== 8'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", bus.result); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
   endtask

   task automatic test_basic_latency();
      int bad;
      bad = 0;
      bus.A = 8'd5; bus.B = 8'd7; bus.N = 8'd13; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      for (int k = 1; k <= DL; k++) begin
         tick();
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL basic_busy_window bad_samples=%0d exp=0", bad); end
      tick();
      checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL basic_done_edge got=%b exp=1", bus.done); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", bus.busy); end
      checks++; if (bus.result !== 8'd1) begin failures++; $display("FAIL basic_result got=%0d exp=1", bus.result); end
      tick();
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
      checks++; if (bus.result !== 8'd1) begin failures++; $display("FAIL basic_result_hold got=%0d exp=1", bus.result); end
   endtask

   task automatic test_domain_conversion();
      int lat; logic [DL-1:0] res; logic e;
      run_op(8'd1, 8'd3, 8'd13, lat, res, e);
      checks++; if (res !== 8'd9 || lat !== DL + 1) begin failures++; $display("FAIL to_domain got=%0d lat=%0d exp=9 lat=%0d", res, lat, DL + 1); end
      run_op(8'd9, 8'd1, 8'd13, lat, res, e);
      checks++; if (res !== 8'd1) begin failures++; $display("FAIL from_domain got=%0d exp=1", res); end
      run_op(8'd12, 8'd12, 8'd13, lat, res, e);
      checks++; if (res !== 8'd3) begin failures++; $display("FAIL mul_12_12 got=%0d exp=3", res); end
      run_op(8'd3, 8'd0, 8'd13, lat, res, e);
      checks++; if (res !== 8'd0) begin failures++; $display("FAIL b_zero got=%0d exp=0", res); end
   endtask

   task automatic test_max_width();
      int lat; logic [DL-1:0] res; logic e;
      run_op(8'd254, 8'd254, 8'd255, lat, res, e);
      checks++; if (res !== 8'd1) begin failures++; $display("FAIL max_254_254 got=%0d exp=1", res); end
      run_op(8'd0, 8'd200, 8'd255, lat, res, e);
      checks++; if (res !== 8'd0) begin failures++; $display("FAIL a_zero got=%0d exp=0", res); end
      run_op(8'd100, 8'd3, 8'd255, lat, res, e);
      checks++; if (res !== 8'd45) begin failures++; $display("FAIL max_100_3 got=%0d exp=45", res); end
   endtask

   task automatic test_back_to_back();
      int first_edge; int second_edge; int edge_no; logic [DL-1:0] res1;
      first_edge = -1; second_edge = -1; edge_no = 0; res1 = '0;
      bus.A = 8'd5; bus.B = 8'd7; bus.N = 8'd13; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 1; k <= 40 && second_edge < 0; k++) begin
         // Ignored request while busy: operands that would give 3 instead of 1.
         if (k == 4) begin bus.A = 8'd1; bus.B = 8'd1; bus.start = 1'b1; end
         tick();
         edge_no = k;
         bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            if (first_edge < 0) begin
               first_edge = edge_no;
               res1 = bus.result;
               bus.A = 8'd2; bus.B = 8'd3; bus.N = 8'd13; bus.start = 1'b1;
            end else begin
               second_edge = edge_no;
            end
         end
      end
      checks++; if (first_edge !== DL + 1) begin failures++; $display("FAIL b2b_first_done got=%0d exp=%0d", first_edge, DL + 1); end
      checks++; if (res1 !== 8'd1) begin failures++; $display("FAIL b2b_first_result got=%0d exp=1", res1); end
      checks++; if (second_edge - first_edge !== DL + 2) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", second_edge - first_edge, DL + 2); end
      checks++; if (bus.result !== 8'd5) begin failures++; $display("FAIL b2b_second_result got=%0d exp=5", bus.result); end
   endtask

   task automatic test_reset_abort();
      int lat; logic [DL-1:0] res; logic e; int dones;
      dones = 0;
      bus.A = 8'd5; bus.B = 8'd7; bus.N = 8'd13; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 1; k <= 4; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.result !== 8'd0) begin failures++; $display("FAIL abort_result got=%0d exp=0", bus.result); end
      for (int k = 0; k < 12; k++) begin
         if (bus.done === 1'b1) dones++;
         tick();
      end
      checks++; if (dones !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
      run_op(8'd5, 8'd7, 8'd13, lat, res, e);
      checks++; if (res !== 8'd1 || lat !== DL + 1) begin failures++; $display("FAIL abort_restart got=%0d lat=%0d exp=1 lat=%0d", res, lat, DL + 1); end
   endtask

   task automatic test_odd_check();
      int lat; logic [DL-1:0] res; logic e;
`ifdef MONT_ODD_CHECK_EN
      run_op(8'd5, 8'd7, 8'd12, lat, res, e);
      checks++; if (e !== 1'b1) begin failures++; $display("FAIL odd_err_set got=%b exp=1", e); end
      checks++; if (res !== 8'd0) begin failures++; $display("FAIL odd_result got=%0d exp=0", res); end
      checks++; if (lat !== 1) begin failures++; $display("FAIL odd_latency got=%0d exp=1", lat); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL odd_busy got=%b exp=0", bus.busy); end
      run_op(8'd5, 8'd7, 8'd13, lat, res, e);
      checks++; if (e !== 1'b0 || res !== 8'd1) begin failures++; $display("FAIL odd_err_clear err=%b res=%0d exp err=0 res=1", e, res); end
      run_op(8'd0, 8'd0, 8'd1, lat, res, e);
      checks++; if (e !== 1'b1 || lat !== 1) begin failures++; $display("FAIL odd_n_one err=%b lat=%0d exp err=1 lat=1", e, lat); end
`else
      run_op(8'd5, 8'd7, 8'd12, lat, res, e);
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL even_n_err got=%b exp=0", e); end
      checks++; if (lat !== DL + 1) begin failures++; $display("FAIL even_n_latency got=%0d exp=%0d", lat, DL + 1); end
      run_op(8'd5, 8'd7, 8'd13, lat, res, e);
      checks++; if (e !== 1'b0 || res !== 8'd1) begin failures++; $display("FAIL after_even err=%b res=%0d exp err=0 res=1", e, res); end
`endif
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.N = 8'd13;
      test_reset();
      test_basic_latency();
      test_domain_conversion();
      test_max_width();
      test_back_to_back();
      test_reset_abort();
      test_odd_check();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
